// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@60 timing constants, error indices and helpers
// Purpose: constants and types shared by vga_frame_monitor and sync_edge_meter.
// Ports: none (package).
package vga_pkg;

  // 800x600@60 timing, 40 MHz pixel clock
  localparam int VGA_H_TOTAL     = 1056;
  localparam int VGA_H_SYNC      = 128;
  localparam int VGA_H_ACT_START = 216;
  localparam int VGA_H_ACTIVE    = 800;
  localparam int VGA_V_TOTAL     = 628;
  localparam int VGA_V_SYNC      = 4;
  localparam int VGA_V_ACT_START = 27;
  localparam int VGA_V_ACTIVE    = 600;

  // err[] bit positions
  localparam int ERR_W           = 6;
  localparam int ERR_LINE_LEN    = 0;
  localparam int ERR_HS_WIDTH    = 1;
  localparam int ERR_LINES       = 2;
  localparam int ERR_VS_WIDTH    = 3;
  localparam int ERR_BLANK_COLOR = 4;
  localparam int ERR_VS_ALIGN    = 5;

  localparam int CSUM_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_RUN,
    ST_DONE
  } mon_state_t;

  // Counters stick at all-ones so a missing sync shows up as a length error
  // instead of wrapping round to a plausible value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_meter.sv
// rtl/sync_edge_meter.sv - sync leading-edge detect and pulse width check
// Purpose: detects the leading edge of one sync signal, counts how long it
//          stays asserted in units of tick, and flags a width mismatch.
// Ports:
//   clk, rst   pixel clock, synchronous active-low reset
//   sync       registered sync input
//   tick       count enable (1 every clock for hs, hs leading edge for vs)
//   check_en   width mismatches are only reported while high
//   lead       leading edge of sync (combinational)
//   width_err  one-cycle flag at deassert when width != EXPECT
module sync_edge_meter
  import vga_pkg::*;
#(
  parameter int   EXPECT = 128,
  parameter logic POL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic tick,
  input  logic check_en,
  output logic lead,
  output logic width_err
);

  logic             active;
  logic             active_q;
  logic [CNT_W-1:0] width;

  assign active    = (sync == POL);
  assign lead      = active & ~active_q;
  assign width_err = check_en & ~active & active_q & (width != CNT_W'(EXPECT));

  // Width keeps counting even while checks are disabled, so the pulse that
  // coincides with lock is still measured in full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= 1'b0;
      width    <= '0;
    end else begin
      active_q <= active;
      if (lead)
        width <= {{(CNT_W-1){1'b0}}, tick};
      else if (active && tick)
        width <= sat_inc(width);
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - cycle-exact VGA sync, window and checksum checker
// Purpose: locks onto the hs/vs stream, checks line length, sync widths,
//          lines per frame and vs/hs alignment, flags colour in blanking and
//          produces a per-frame rotate-XOR checksum of the active pixels.
// Ports:
//   clk, rst        pixel clock, synchronous active-low reset
//   hs, vs, r, g, b VGA stream under test
//   locked          high from the first vs leading edge
//   frame_done      one-cycle pulse per completed checked frame
//   frame_cnt       completed checked frames
//   checksum        checksum of the last completed frame
//   err             sticky error flags (see vga_pkg ERR_*)
//   done            high once frame_cnt == FRAMES
module vga_frame_monitor
  import vga_pkg::*;
#(
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_ACT_START = VGA_H_ACT_START,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_ACT_START = VGA_V_ACT_START,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter logic HS_POL      = 1'b1,
  parameter logic VS_POL      = 1'b1,
  parameter int   COLOR_W     = 4,
  parameter int   FRAMES      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               locked,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic [31:0]        checksum,
  output logic [ERR_W-1:0]   err,
  output logic               done
);

  localparam logic [CNT_W-1:0] H_TOT_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOT_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_LO     = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_HI     = CNT_W'(H_ACT_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO     = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_HI     = CNT_W'(V_ACT_START + V_ACTIVE);
  localparam logic [15:0]      FRAMES_C = 16'(FRAMES);

  mon_state_t          state;
  logic                hs_q, vs_q;
  logic [COLOR_W-1:0]  r_q, g_q, b_q;
  logic                hs_lead, vs_lead, hs_width_err, vs_width_err;
  logic                running, skip_h, in_win;
  logic [CNT_W-1:0]    hcnt, vcnt, hpos, vpos, line_cnt;
  logic [CSUM_W-1:0]   csum, csum_base, csum_next, pix_word;
  logic [ERR_W-1:0]    err_now;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      r_q  <= r;
      g_q  <= g;
      b_q  <= b;
    end
  end

  assign running = (state == ST_RUN);

  sync_edge_meter #(.EXPECT(H_SYNC), .POL(HS_POL)) u_hs_meter (
    .clk(clk), .rst(rst), .sync(hs_q), .tick(1'b1), .check_en(running),
    .lead(hs_lead), .width_err(hs_width_err)
  );

  // vs width is measured in lines, so it ticks on hs leading edges
  sync_edge_meter #(.EXPECT(V_SYNC), .POL(VS_POL)) u_vs_meter (
    .clk(clk), .rst(rst), .sync(vs_q), .tick(hs_lead), .check_en(running),
    .lead(vs_lead), .width_err(vs_width_err)
  );

  // hpos/vpos are the coordinates of the pixel being sampled now; hcnt/vcnt
  // hold those of the previous pixel. Outside RUN the only use is the lock
  // clock, which by definition is pixel (0,0).
  always_comb begin
    hpos = (hs_lead || !running) ? '0 : sat_inc(hcnt);
    if (vs_lead || !running)
      vpos = '0;
    else if (hs_lead)
      vpos = sat_inc(vcnt);
    else
      vpos = vcnt;
    // lines seen since the last vs edge, including one starting this clock
    line_cnt = hs_lead ? sat_inc(vcnt) : vcnt;
  end

  assign in_win   = (hpos >= H_LO) && (hpos < H_HI) && (vpos >= V_LO) && (vpos < V_HI);
  assign pix_word = CSUM_W'({r_q, g_q, b_q});

  // A vs edge starts a new frame, so the current pixel belongs to the fresh sum
  always_comb begin
    csum_base = vs_lead ? '0 : csum;
    csum_next = in_win ? ({csum_base[CSUM_W-2:0], csum_base[CSUM_W-1]} ^ pix_word)
                       : csum_base;
  end

  always_comb begin
    err_now                  = '0;
    err_now[ERR_LINE_LEN]    = running && hs_lead && !skip_h && (sat_inc(hcnt) != H_TOT_C);
    err_now[ERR_HS_WIDTH]    = hs_width_err;
    err_now[ERR_LINES]       = running && vs_lead && (line_cnt != V_TOT_C);
    err_now[ERR_VS_WIDTH]    = vs_width_err;
    err_now[ERR_BLANK_COLOR] = running && !in_win && (|{r_q, g_q, b_q});
    err_now[ERR_VS_ALIGN]    = running && vs_lead && !hs_lead;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      checksum   <= '0;
      err        <= '0;
      done       <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      csum       <= '0;
      skip_h     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_SEEK;
        ST_SEEK: begin
          if (vs_lead) begin
            state  <= ST_RUN;
            locked <= 1'b1;
            hcnt   <= hpos;
            vcnt   <= vpos;
            csum   <= csum_next;
            // lock may land mid-line, so the first line length is unknown
            skip_h <= 1'b1;
          end
        end
        ST_RUN: begin
          hcnt <= hpos;
          vcnt <= vpos;
          csum <= csum_next;
          err  <= err | err_now;
          if (hs_lead)
            skip_h <= 1'b0;
          if (vs_lead) begin
            checksum   <= csum;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            if (frame_cnt + 16'd1 == FRAMES_C) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - scoreboard bench for vga_frame_monitor on a small timing set
module tb_vga_frame_monitor;

  localparam int   HT  = 16;
  localparam int   HSY = 3;
  localparam int   HAS = 6;
  localparam int   HA  = 4;
  localparam int   VT  = 8;
  localparam int   VSY = 2;
  localparam int   VAS = 3;
  localparam int   VA  = 2;
  localparam int   FR  = 2;
  localparam int   CW  = 4;
  localparam logic HP  = 1'b1;
  localparam logic VP  = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hs, vs;
  logic [CW-1:0] r, g, b;
  logic          locked, frame_done, done;
  logic [15:0]   frame_cnt;
  logic [31:0]   checksum;
  logic [5:0]    err;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   sb_q[$];
  int            fd_seen = 0;
  int            fd_gap = 0;
  time           last_fd_t = 0;

  always #5 clk = ~clk;

  vga_frame_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_ACT_START(VAS), .V_ACTIVE(VA),
    .HS_POL(HP), .VS_POL(VP), .COLOR_W(CW), .FRAMES(FR)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .checksum(checksum), .err(err), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        fd_seen = 0;
      end else if (frame_done) begin
        fd_seen++;
        fd_gap    = int'(($time - last_fd_t) / 10);
        last_fd_t = $time;
        check_eq("sb_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0)
          check_eq("checksum", checksum, sb_q.pop_front());
        check_eq("frame_cnt_at_fd", frame_cnt, fd_seen);
        check_eq("done_at_fd", done, fd_seen == FR);
      end
    end
  endtask

  task automatic drive_idle();
    hs = ~HP;
    vs = ~VP;
    {r, g, b} = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives nframes full frames plus `tail` lines of one more so the final
  // frame gets closed by a vs edge. Fault knobs apply to frame 0 only.
  task automatic run_stream(input int nframes, input int tail, input bit colour,
                            input int short_y, input int narrow_y, input int blank_y,
                            input int vdelay);
    logic [31:0] model;
    logic [11:0] col;
    int          len, hsw, nlines;
    bit          vs_on, in_win;
    repeat (3) begin
      @(posedge clk); #1;
      drive_idle();
    end
    @(negedge clk);
    check_eq("locked_before_vs", locked, 0);
    for (int f = 0; f <= nframes; f++) begin
      model  = '0;
      nlines = (f == nframes) ? tail : VT;
      for (int y = 0; y < nlines; y++) begin
        len = (f == 0 && y == short_y) ? HT - 1 : HT;
        hsw = (f == 0 && y == narrow_y) ? HSY - 1 : HSY;
        for (int x = 0; x < len; x++) begin
          @(posedge clk); #1;
          hs     = (x < hsw) ? HP : ~HP;
          vs_on  = (y == 0 && x >= vdelay) || (y > 0 && y < VSY) || (y == VSY && x < vdelay);
          vs     = vs_on ? VP : ~VP;
          in_win = (x >= HAS) && (x < HAS + HA) && (y >= VAS) && (y < VAS + VA);
          col    = '0;
          if (in_win && colour)
            col = 12'(f * 151 + y * 37 + x * 11 + 1);
          if (in_win)
            model = {model[30:0], model[31]} ^ {20'd0, col};
          if (f == 0 && y == blank_y && x == 0)
            col = 12'hF00;
          {r, g, b} = col;
          if (f == 0 && y == 0 && x == vdelay + 2) begin
            @(negedge clk);
            check_eq("locked_after_vs", locked, 1);
          end
        end
      end
      if (f < nframes)
        sb_q.push_back(model);
    end
  endtask

  task automatic end_checks(input string pfx, input logic [5:0] exp_err);
    repeat (3) @(negedge clk);
    check_eq({pfx, "_err"}, err, exp_err);
    check_eq({pfx, "_done"}, done, 1);
    check_eq({pfx, "_locked"}, locked, 1);
    check_eq({pfx, "_frame_cnt"}, frame_cnt, FR);
    check_eq({pfx, "_frames_seen"}, fd_seen, FR);
    check_eq({pfx, "_sb_left"}, sb_q.size(), 0);
  endtask

  task automatic reset_value_checks(input string pfx);
    check_eq({pfx, "_locked"}, locked, 0);
    check_eq({pfx, "_frame_done"}, frame_done, 0);
    check_eq({pfx, "_frame_cnt"}, frame_cnt, 0);
    check_eq({pfx, "_checksum"}, checksum, 0);
    check_eq({pfx, "_err"}, err, 0);
    check_eq({pfx, "_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_value_checks("rst");

    // clean stream with incrementing colour in the active window
    do_reset();
    run_stream(FR, 2, 1'b1, -1, -1, -1, 0);
    end_checks("clean", 6'b000000);
    check_eq("clean_fd_gap", fd_gap, HT * VT);

    // one short line in frame 0: only the line length flag, sticky to the end
    do_reset();
    run_stream(FR, 2, 1'b0, 3, -1, -1, 0);
    end_checks("short_line", 6'b000001);

    // narrow hs pulse plus a lit pixel in blanking at x=0
    do_reset();
    run_stream(FR, 2, 1'b0, -1, 1, 2, 0);
    end_checks("hs_width_blank", 6'b010010);

    // vs leading edge 3 clocks after the hs edge
    do_reset();
    run_stream(FR, 2, 1'b0, -1, -1, -1, 3);
    end_checks("vs_late", 6'b100000);

    // reset mid-frame, then a clean stream must relock from scratch
    do_reset();
    run_stream(0, 4, 1'b1, -1, -1, -1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_value_checks("mid_rst");
    #1 rst = 1'b1;
    run_stream(FR, 2, 1'b1, -1, -1, -1, 0);
    end_checks("relock", 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Synthesizable, parametrised frame checker that sits on the VGA output of the display design (hs, vs, r, g, b) and replaces visual waveform inspection with cycle-exact checks. It locks onto the sync stream and measures line length, sync widths and lines per frame against parameters. It flags colour outside the active window and produces a per-frame 32-bit checksum of the active pixels. After FRAMES frames it raises `done`, so benches and on-board debug logic can stop or report without a human in the loop.

## Interface
- `H_TOTAL`, 1056, clocks per line
- `H_SYNC`, 128, hs pulse width in clocks
- `H_ACT_START`, 216, clocks from hs leading edge to first active pixel
- `H_ACTIVE`, 800, active pixels per line
- `V_TOTAL`, 628, lines per frame
- `V_SYNC`, 4, vs pulse width in lines
- `V_ACT_START`, 27, lines from vs leading edge to first active line
- `V_ACTIVE`, 600, active lines per frame
- `HS_POL` / `VS_POL`, 1 / 1, active level of each sync
- `COLOR_W`, 4, bits per colour channel (3*COLOR_W ≤ 32)
- `FRAMES`, 2, frames to check before `done`
- `clk`  in  1  pixel-rate clock
- `rst`  in  1  synchronous, active-low reset
- `hs`, `vs`  in  1 each  sync inputs
- `r`, `g`, `b`  in  COLOR_W each  pixel colour
- `locked`  out  1  high from the first vs leading edge
- `frame_done`  out  1  one-cycle pulse at each completed checked frame
- `frame_cnt`  out  16  completed checked frames
- `checksum`  out  32  checksum of the last completed frame
- `err`  out  6  sticky flags: [0] line length, [1] hs width, [2] lines/frame, [3] vs width, [4] colour in blanking, [5] vs/hs misalignment
- `done`  out  1  high once frame_cnt == FRAMES

## Operation
- A sync input is asserted when it equals its POL parameter. Its leading edge is asserted now and deasserted on the previous clock. Edge registers reset to the deasserted level.
- States:
  - IDLE: entered from reset. Moves to SEEK on the first clock with rst high.
  - SEEK: no checks run. On a vs leading edge, go to RUN, set `locked`, hcnt=0, vcnt=0, clear the running checksum.
- RUN: hcnt increments each clock and saturates at all-ones. On an hs leading edge:
  - If hcnt+1 ≠ H_TOTAL, set err[0]. This check is skipped for the first hs edge after lock.
  - Set hcnt=0 and increment vcnt.
- hs width: count the clocks hs stays asserted. If the count ≠ H_SYNC when hs deasserts, set err[1]. vs width is counted in hs leading edges; if the count ≠ V_SYNC at vs deassert, set err[3].
- A vs leading edge in RUN ends the frame:
  - Set err[2] if the line count ≠ V_TOTAL.
  - Set err[5] if the same clock is not also an hs leading edge.
  - Latch `checksum`, pulse `frame_done`, increment `frame_cnt`, clear the running checksum, and set vcnt=0.
  - If frame_cnt reaches FRAMES, go to DONE.
- Active window: H_ACT_START ≤ hcnt < H_ACT_START+H_ACTIVE and V_ACT_START ≤ vcnt < V_ACT_START+V_ACTIVE.
  - Inside the window: csum ← {csum[30:0], csum[31]} XOR zero-extended {r,g,b}.
  - Outside the window: any nonzero r/g/b sets err[4].
- DONE: `done`=1. Counters, checksum, `frame_cnt` and `err` freeze. Only reset leaves DONE.
- `err` bits are sticky until reset. Simultaneous errors all set in the same clock.

## Timing
- Reset values: `locked`=0, `frame_done`=0, `frame_cnt`=0, `checksum`=0, `err`=0, `done`=0.
- Inputs are registered once, so every flag and counter lags the input edge by one clock. `frame_done`, the `checksum` update and the `frame_cnt` increment appear one clock after the vs leading edge is sampled.
- `done` rises in the same clock as the final `frame_done`.
- Reset low mid-frame: all outputs return to reset values on the next clock edge. A partial frame is discarded, and the block re-seeks after reset releases.
- Saturation: hcnt and vcnt never wrap. A missing hs or vs therefore produces a length error, not an aliased pass.

## Structure
- Shared package `vga_pkg`:
  - 800x600@60 timing constants (the parameter defaults above).
  - Error bit index constants.
  - Checksum width.
- Natural sub-module: `sync_edge_meter`, instantiated twice (hs in clock units, vs in line units). Each instance covers edge detect, pulse width counting and compare against the expected width.
- Top level holds the state machine, position counters, window decode and checksum.

## Test plan
- Nominal 800x600 bench generator with all-zero colour, FRAMES=2 → `locked` at the first vs edge, two `frame_done` pulses 663168 clocks apart, `frame_cnt`=2, `done`=1, `err`=0, `checksum`=0.
- Small parameter set (H_TOTAL=16, V_TOTAL=8, H_ACTIVE=4, V_ACTIVE=2) with an incrementing colour pattern → `checksum` equals the bench reference model value each frame, `err`=0.
- One line shortened to 1055 clocks in frame 1 → err[0]=1 and err[2]=0, other bits 0; err[0] stays set through frame 2.
- hs width 127 on one line plus r=4'hF for one pixel at hcnt=0 → err[1]=1 and err[4]=1.
- vs leading edge delayed 3 clocks after the hs edge → err[5]=1.
- rst low for 5 clocks mid-frame 1, then a clean stream → all outputs reset, relock on the next vs edge, two clean frames, `err`=0.
